// File: rtl/svo_fb_pkg.sv
// Shared types and helpers for the frame-buffer video source.
// Holds the default geometry, FSM encoding and the RGB565 -> {B,G,R} expansion.
package svo_fb_pkg;

  localparam int FB_WIDTH_DEF  = 320;
  localparam int FB_HEIGHT_DEF = 240;
  localparam int OUT_W         = 2 * FB_WIDTH_DEF;
  localparam int OUT_H         = 2 * FB_HEIGHT_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fb_state_t;

  // Bit replication maps full-scale 5/6-bit channels onto full-scale 8-bit ones.
  function automatic logic [23:0] rgb565_to_bgr888(input logic [15:0] d);
    return {d[4:0], d[4:2], d[10:5], d[10:9], d[15:11], d[15:13]};
  endfunction

endpackage

// File: rtl/svo_fb_skid_fifo.sv
// Two-entry FIFO of {sof, pixel} sitting in front of an AXI-stream output.
// The head entry is presented on dout and stays put until popped.
module svo_fb_skid_fifo #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [1:0][W-1:0] mem;
  logic              rd_ptr;
  logic              wr_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem    <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/svo_fb_reader.sv
// Frame-buffer video source: reads the RGB565 buffer, scales 2x by replication
// and emits one SVO AXI-stream frame per enabled frame period.
module svo_fb_reader
  import svo_fb_pkg::*;
#(
  parameter int SVO_BITS_PER_PIXEL = 24,
  parameter int FB_WIDTH           = FB_WIDTH_DEF,
  parameter int FB_HEIGHT          = FB_HEIGHT_DEF,
  parameter int FB_ADDR_BITS       = 17
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  output logic                          fb_rd_en,
  output logic [FB_ADDR_BITS-1:0]       fb_rd_addr,
  input  logic [15:0]                   fb_rd_data,
  output logic                          out_axis_tvalid,
  input  logic                          out_axis_tready,
  output logic [SVO_BITS_PER_PIXEL-1:0] out_axis_tdata,
  output logic                          out_axis_tuser
);

  localparam int OW = 2 * FB_WIDTH;
  localparam int OH = 2 * FB_HEIGHT;
  localparam int XW = $clog2(OW);
  localparam int YW = $clog2(OH);
  localparam logic [XW-1:0]           OX_LAST  = XW'(OW - 1);
  localparam logic [YW-1:0]           OY_LAST  = YW'(OH - 1);
  localparam logic [FB_ADDR_BITS-1:0] ROW_STEP = FB_ADDR_BITS'(FB_WIDTH);

  fb_state_t                   state, state_n;
  logic [XW-1:0]               ox, ox_n;
  logic [YW-1:0]               oy, oy_n;
  logic [FB_ADDR_BITS-1:0]     row_base, row_base_n, addr_n;
  logic                        issue, last_col, last_px, drained;
  logic                        inflight, rd_sof, fifo_pop;
  logic [1:0]                  fifo_count;
  logic [SVO_BITS_PER_PIXEL:0] fifo_dout;

  assign last_col        = (ox == OX_LAST);
  assign last_px         = last_col && (oy == OY_LAST);
  assign drained         = !inflight && (fifo_count == 2'd0);
  assign out_axis_tvalid = (fifo_count != 2'd0);
  assign fifo_pop        = out_axis_tvalid && out_axis_tready;
  assign out_axis_tdata  = fifo_dout[SVO_BITS_PER_PIXEL-1:0];
  assign out_axis_tuser  = out_axis_tvalid && fifo_dout[SVO_BITS_PER_PIXEL];
  assign fb_rd_en        = issue;

  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (enable) state_n = ST_RUN;
      ST_RUN:   if (issue && last_px) state_n = ST_DRAIN;
      ST_DRAIN: if (drained) state_n = enable ? ST_RUN : ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // A slot freed by this cycle's pop is reusable at once, so one read per cycle
  // keeps flowing while fifo entries plus the read in flight never exceed two.
  always_comb begin
    issue = (state == ST_RUN) &&
            (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, fifo_pop}));
  end

  always_comb begin
    ox_n       = ox;
    oy_n       = oy;
    row_base_n = row_base;
    if (state == ST_DRAIN && drained) begin
      ox_n       = '0;
      oy_n       = '0;
      row_base_n = '0;
    end else if (issue) begin
      if (last_col) begin
        ox_n = '0;
        if (!last_px) begin
          oy_n = oy + 1'b1;
          // Each source line is shown twice; advance only after the odd copy.
          if (oy[0]) row_base_n = row_base + ROW_STEP;
        end
      end else begin
        ox_n = ox + 1'b1;
      end
    end
    addr_n = row_base_n + FB_ADDR_BITS'(ox_n >> 1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ox         <= '0;
      oy         <= '0;
      row_base   <= '0;
      fb_rd_addr <= '0;
      inflight   <= 1'b0;
      rd_sof     <= 1'b0;
    end else begin
      ox         <= ox_n;
      oy         <= oy_n;
      row_base   <= row_base_n;
      fb_rd_addr <= addr_n;
      inflight   <= issue;
      rd_sof     <= issue && (ox == '0) && (oy == '0);
    end
  end

  svo_fb_skid_fifo #(.W(SVO_BITS_PER_PIXEL + 1)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (inflight),
    .din    ({rd_sof, SVO_BITS_PER_PIXEL'(rgb565_to_bgr888(fb_rd_data))}),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .count  (fifo_count)
  );

endmodule

// File: tb/tb_svo_fb_reader.sv
// Randomized bench for svo_fb_reader on a reduced 20x6 buffer (40x12 output)
// against a raster model computed directly from pixel index arithmetic.
module tb_svo_fb_reader;

  localparam int FW = 20;
  localparam int FH = 6;
  localparam int AB = 17;
  localparam int OW = 2 * FW;
  localparam int OH = 2 * FH;
  localparam int N  = OW * OH;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          tready = 1'b1;
  logic          fb_rd_en;
  logic [AB-1:0] fb_rd_addr;
  logic [15:0]   fb_rd_data = 16'h0;
  logic          tvalid;
  logic [23:0]   tdata;
  logic          tuser;

  int total = 0;
  int bad = 0;
  int beat = 0;
  int issued = 0;
  int consumed = 0;
  int cyc = 0;
  int mode = 0;
  bit rnd = 1'b0;
  logic [15:0] const_val = 16'h0;
  logic [23:0] cap [N];
  logic        prev_stall = 1'b0;
  logic [23:0] prev_data = 24'h0;

  always #5 clk = ~clk;

  svo_fb_reader #(
    .SVO_BITS_PER_PIXEL(24), .FB_WIDTH(FW), .FB_HEIGHT(FH), .FB_ADDR_BITS(AB)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .enable          (enable),
    .fb_rd_en        (fb_rd_en),
    .fb_rd_addr      (fb_rd_addr),
    .fb_rd_data      (fb_rd_data),
    .out_axis_tvalid (tvalid),
    .out_axis_tready (tready),
    .out_axis_tdata  (tdata),
    .out_axis_tuser  (tuser)
  );

  function automatic logic [15:0] ram_val(input int a);
    int h;
    if (mode == 0) return a[15:0];
    if (mode == 1) return const_val;
    h = (a * 40503) ^ 23130;
    return h[15:0];
  endfunction

  function automatic logic [23:0] expand(input int d);
    int r, g, b;
    r = (d >> 11) & 31;
    g = (d >> 5) & 63;
    b = d & 31;
    return 24'((((b << 3) | (b >> 2)) << 16) | (((g << 2) | (g >> 4)) << 8) | ((r << 3) | (r >> 2)));
  endfunction

  function automatic logic [23:0] model_px(input int k);
    int p, x, y;
    p = k % N;
    x = p % OW;
    y = p / OW;
    return expand(int'(ram_val((y / 2) * FW + x / 2)));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (fb_rd_en) fb_rd_data <= ram_val(int'(fb_rd_addr));
  end

  always @(posedge clk) begin
    #1;
    tready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  // Single compare process: every transfer against the model, plus hold and credit checks.
  always @(negedge clk) begin
    if (!resetn) begin
      beat = 0;
      issued = 0;
      consumed = 0;
      prev_stall = 1'b0;
    end else begin
      chk("outstanding_le_2", 32'(issued - consumed <= 2), 32'd1);
      if (prev_stall) begin
        chk("hold_tvalid", 32'(tvalid), 32'd1);
        chk("hold_tdata", 32'(tdata), 32'(prev_data));
      end
      if (tvalid && tready) begin
        chk("tdata", 32'(tdata), 32'(model_px(beat)));
        chk("tuser", 32'(tuser), 32'(beat % N == 0));
        if (beat < N) cap[beat] = tdata;
        beat++;
        consumed++;
      end
      if (fb_rd_en) issued++;
      prev_stall = tvalid && !tready;
      prev_data = tdata;
    end
  end

  task automatic wait_beats(input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (beat < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(beat >= target), 32'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_rd_en", 32'(fb_rd_en), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    resetn = 1'b1;
  endtask

  task automatic check_idle(input int frames);
    repeat (30) @(negedge clk);
    chk("idle_beats", 32'(beat), 32'(frames * N));
    chk("idle_issued", 32'(issued), 32'(frames * N));
    chk("idle_rd_en", 32'(fb_rd_en), 32'd0);
    chk("idle_tvalid", 32'(tvalid), 32'd0);
  endtask

  task automatic first_read_at_zero();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (fb_rd_en) begin
        seen = 1'b1;
        chk("first_addr", 32'(fb_rd_addr), 32'd0);
      end
    end
    chk("first_read_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    int c0, c1;
    logic [15:0] cin [4];
    logic [23:0] cout [4];
    cin[0] = 16'hF800; cout[0] = 24'h0000FF;
    cin[1] = 16'h07E0; cout[1] = 24'h00FF00;
    cin[2] = 16'h001F; cout[2] = 24'hFF0000;
    cin[3] = 16'h0841; cout[3] = 24'h080808;

    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle0_rd_en", 32'(fb_rd_en), 32'd0);
      chk("idle0_tvalid", 32'(tvalid), 32'd0);
      chk("idle0_tdata", 32'(tdata), 32'd0);
    end

    // Address-pattern frame with tready held high.
    mode = 0;
    enable = 1'b1;
    c0 = -1;
    c1 = -1;
    for (int i = 0; i < 10 && c0 < 0; i++) begin
      @(negedge clk);
      if (fb_rd_en) begin
        c0 = cyc;
        chk("first_addr", 32'(fb_rd_addr), 32'd0);
      end
    end
    for (int i = 0; i < 10 && c1 < 0; i++) begin
      @(negedge clk);
      if (tvalid) begin
        c1 = cyc;
        chk("first_tuser", 32'(tuser), 32'd1);
      end
    end
    chk("latency", 32'(c1 - c0), 32'd2);
    wait_beats(50, 500, "timeout_a50");
    enable = 1'b0;
    wait_beats(N, 5 * N, "timeout_a_frame");
    check_idle(1);
    chk("pix_1_0", 32'(cap[1]), 32'h000000);
    chk("pix_2_1", 32'(cap[OW + 2]), 32'h080000);
    chk("pix_0_2", 32'(cap[2 * OW]), 32'hA50000);
    chk("pix_last", 32'(cap[N - 1]), 32'hBD0C00);

    // Colour expansion corners; each restart also exercises reset mid-frame.
    for (int i = 0; i < 4; i++) begin
      pulse_reset();
      mode = 1;
      const_val = cin[i];
      enable = 1'b1;
      wait_beats(3, 50, "timeout_colour");
      chk("colour", 32'(cap[0]), 32'(cout[i]));
    end

    // Pseudo-random buffer, 30% tready, reset mid-frame, then two full frames.
    pulse_reset();
    mode = 2;
    rnd = 1'b1;
    enable = 1'b1;
    wait_beats(100, 2000, "timeout_c100");
    pulse_reset();
    first_read_at_zero();
    wait_beats(N + 10, 10 * N, "timeout_c_frame1");
    enable = 1'b0;
    wait_beats(2 * N, 10 * N, "timeout_c_frame2");
    check_idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
